// File: rtl/pip_stage_skid.sv
// pip_stage_skid: valid/ready pipeline stage register with optional skid entry and flush-to-bubble
module pip_stage_skid #(
    parameter int                    DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_DATA = {32'h00000013, 32'hBFC00000},
    parameter bit                    SKID_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  stall,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            occupancy
);
    logic                  m_vld_q, m_vld_d, s_vld_q, s_vld_d;
    logic [DATA_WIDTH-1:0] m_dat_q, m_dat_d, s_dat_q, s_dat_d;
    logic                  rdy_eff, in_fire, out_fire, drain, skid_fire;
    assign rdy_eff   = out_ready & ~stall;
    assign in_ready  = SKID_EN ? ~s_vld_q : (~m_vld_q | rdy_eff);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = m_vld_q & rdy_eff;
    assign drain     = ~m_vld_q | out_fire;
    assign skid_fire = in_fire & SKID_EN;
    assign out_valid = m_vld_q;
    assign out_data  = m_vld_q ? m_dat_q : BUBBLE_DATA;
    assign occupancy = {1'b0, m_vld_q} + {1'b0, s_vld_q};
    // a full skid entry always refills main first; in_ready is low then, so no capture can collide
    always_comb begin
        m_vld_d = drain ? (s_vld_q | in_fire) : m_vld_q;
        m_dat_d = drain ? (s_vld_q ? s_dat_q : in_fire ? in_data : BUBBLE_DATA) : m_dat_q;
        s_vld_d = drain ? 1'b0 : (s_vld_q | skid_fire);
        s_dat_d = drain ? BUBBLE_DATA : skid_fire ? in_data : s_dat_q;
    end
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            m_vld_q <= 1'b0;
            s_vld_q <= 1'b0;
            m_dat_q <= BUBBLE_DATA;
            s_dat_q <= BUBBLE_DATA;
        end else begin
            m_vld_q <= m_vld_d;
            s_vld_q <= s_vld_d;
            m_dat_q <= m_dat_d;
            s_dat_q <= s_dat_d;
        end
    end
endmodule

// File: tb/tb_pip_stage_skid.sv
// tb_pip_stage_skid: skid and single-entry stages side by side against a queue-based reference model
module tb_pip_stage_skid;
    localparam logic [63:0] BUB = 64'h00000013_BFC00000;
    logic              clk = 1'b0;
    logic              rst = 1'b1, flush = 1'b0, stall = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [63:0]       in_data = '0;
    logic [1:0]        in_ready_v, out_valid_v;
    logic [1:0][63:0]  out_data_v;
    logic [1:0][1:0]   occ_v;
    logic              rdy_eff, mon_on = 1'b0;
    logic [63:0]       q0[$], q1[$];
    int                n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    assign rdy_eff = out_ready & ~stall;
    pip_stage_skid #(.SKID_EN(1'b1)) u_sk (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready_v[0]), .in_data(in_data),
        .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_data(out_data_v[0]),
        .occupancy(occ_v[0])
    );
    pip_stage_skid #(.SKID_EN(1'b0)) u_ns (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready_v[1]), .in_data(in_data),
        .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_data(out_data_v[1]),
        .occupancy(occ_v[1])
    );
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // Model: the queue holds exactly the payloads the stage currently owns, head first.
    task automatic mon_one(input int k);
        int          sz;
        logic [63:0] hd;
        logic        er;
        string       p;
        p  = k != 0 ? "ns" : "sk";
        sz = k != 0 ? q1.size() : q0.size();
        hd = sz == 0 ? BUB : (k != 0 ? q1[0] : q0[0]);
        er = k != 0 ? (sz == 0 || rdy_eff) : (sz < 2);
        chk({p, "_out_valid"}, 64'(out_valid_v[k]), 64'(sz != 0));
        chk({p, "_out_data"}, out_data_v[k], hd);
        chk({p, "_occupancy"}, 64'(occ_v[k]), 64'(sz));
        chk({p, "_in_ready"}, 64'(in_ready_v[k]), 64'(er));
        if (rst || flush) begin
            if (k != 0) q1.delete(); else q0.delete();
        end else begin
            if (sz != 0 && rdy_eff) begin
                if (k != 0) void'(q1.pop_front()); else void'(q0.pop_front());
            end
            if (in_valid && in_ready_v[k]) begin
                if (k != 0) q1.push_back(in_data); else q0.push_back(in_data);
            end
        end
    endtask
    always @(negedge clk) begin
        if (mon_on) begin
            mon_one(0);
            mon_one(1);
        end
    end
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [63:0] dv(input int i);
        return 64'hD000_0000_0000_0000 | 64'(i);
    endfunction
    initial begin
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        mon_on = 1'b1;
        chk("t1_out_valid", 64'(out_valid_v[0]), 64'd0);
        chk("t1_out_data", out_data_v[0], BUB);
        chk("t1_in_ready", 64'(in_ready_v[0]), 64'd1);
        chk("t1_occupancy", 64'(occ_v[0]), 64'd0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = dv(i);
            cyc();
            chk("t2_out_data", out_data_v[0], dv(i));
            chk("t2_occupancy", 64'(occ_v[0]), 64'd1);
        end
        in_valid = 1'b0;
        cyc();
        in_valid = 1'b1;
        in_data = dv(0);
        cyc();
        in_data = dv(1);
        cyc();
        out_ready = 1'b0;
        in_data = dv(2);
        cyc();
        in_data = dv(3);
        for (int i = 0; i < 2; i++) begin
            chk("t3_held_data", out_data_v[0], dv(1));
            chk("t3_occupancy", 64'(occ_v[0]), 64'd2);
            chk("t3_in_ready", 64'(in_ready_v[0]), 64'd0);
            cyc();
        end
        out_ready = 1'b1;
        chk("t3_resume_d1", out_data_v[0], dv(1));
        cyc();
        chk("t3_resume_d2", out_data_v[0], dv(2));
        chk("t3_ready_back", 64'(in_ready_v[0]), 64'd1);
        cyc();
        chk("t3_resume_d3", out_data_v[0], dv(3));
        in_valid = 1'b0;
        cyc();
        chk("t3_empty", 64'(out_valid_v[0]), 64'd0);
        in_valid = 1'b1;
        out_ready = 1'b0;
        in_data = dv(4);
        cyc();
        in_data = dv(5);
        cyc();
        chk("t4_full", 64'(occ_v[0]), 64'd2);
        flush = 1'b1;
        in_data = dv(9);
        cyc();
        chk("t4_out_valid", 64'(out_valid_v[0]), 64'd0);
        chk("t4_out_data", out_data_v[0], BUB);
        chk("t4_occupancy", 64'(occ_v[0]), 64'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        stall = 1'b1;
        cyc();
        in_valid = 1'b1;
        for (int i = 6; i < 9; i++) begin
            in_data = dv(i);
            cyc();
        end
        chk("t5_held_data", out_data_v[0], dv(6));
        chk("t5_occupancy", 64'(occ_v[0]), 64'd2);
        stall = 1'b0;
        in_valid = 1'b0;
        repeat (3) cyc();
        chk("t5_drained", 64'(out_valid_v[0]), 64'd0);
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom % 3) != 0;
            stall     = ($urandom % 5) == 0;
            flush     = ($urandom % 40) == 0;
            rst       = ($urandom % 200) == 0;
            cyc();
        end
        {in_valid, stall, flush, rst} = 4'b0;
        out_ready = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
